// File: rtl/readout_pkg.sv
// Shared definitions for the readout scheduler slice.
// Holds the default geometry of the channel register map, the fixed output
// widths, the scheduler state type and the register-address helper.
package readout_pkg;

    localparam int unsigned DEF_CH_REG_START_ADDR = 12;
    localparam int unsigned DEF_NUM_REGS_PER_CH   = 7;
    localparam int unsigned DEF_NUM_CH            = 8;
    localparam int unsigned DEF_BITS_PER_REG      = 8;

    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned CH_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SHIFT,
        DONE
    } state_e;

    // Address of register idx of channel ch in the channel register map.
    function automatic logic [ADDR_W-1:0] ch_reg_addr(
        input int unsigned start,
        input int unsigned nregs,
        input int unsigned ch,
        input int unsigned idx
    );
        return ADDR_W'(start + ch * nregs + idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req        - per-channel request vector
//   last_grant - channel granted most recently
//   grant      - lowest requesting channel strictly after last_grant (wraps)
//   valid      - high when any channel is requesting
module rr_arbiter
    import readout_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] last_grant,
    output logic [CH_IDX_W-1:0] grant,
    output logic                valid
);

    logic [CH_IDX_W-1:0] cand;

    // Walk the channels starting just after last_grant; last_grant itself is
    // visited last so a sole requester can still be re-granted.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = CH_IDX_W'((32'(last_grant) + k) % NUM_CH);
            if (!valid && req[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_scheduler.sv
// Readout scheduler: picks requesting channels round-robin and steps the
// POCI register address through each granted channel's register block,
// holding every address for BITS_PER_REG spi_clk cycles.
// Ports:
//   spi_clk    - sole clock, rising edge
//   rst        - synchronous active-high reset
//   DVDD, DVSS - local power pins, no logic function
//   enable     - permits new frames to start
//   ch_req     - per-channel readout request (level)
//   addr       - register address to the POCI output mux (0 when idle)
//   cur_ch     - channel currently being read out
//   busy       - high while arbitrating or shifting
//   ch_ack     - one-cycle one-hot pulse when a channel frame completes
module readout_scheduler
    import readout_pkg::*;
#(
    parameter int unsigned CH_REG_START_ADDR = DEF_CH_REG_START_ADDR,
    parameter int unsigned NUM_REGS_PER_CH   = DEF_NUM_REGS_PER_CH,
    parameter int unsigned NUM_CH            = DEF_NUM_CH,
    parameter int unsigned BITS_PER_REG      = DEF_BITS_PER_REG
) (
    input  logic                spi_clk,
    input  logic                rst,
    inout  wire                 DVDD,
    inout  wire                 DVSS,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_req,
    output logic [ADDR_W-1:0]   addr,
    output logic [CH_IDX_W-1:0] cur_ch,
    output logic                busy,
    output logic [NUM_CH-1:0]   ch_ack
);

    localparam int unsigned BC_W = (BITS_PER_REG > 1) ? $clog2(BITS_PER_REG) : 1;
    localparam int unsigned RI_W = (NUM_REGS_PER_CH > 1) ? $clog2(NUM_REGS_PER_CH) : 1;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [CH_IDX_W-1:0] cur_ch_q;
    logic                busy_q;
    logic [NUM_CH-1:0]   ch_ack_q;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [RI_W-1:0]     reg_idx_q, reg_idx_d;
    logic [CH_IDX_W-1:0] last_grant_q;

    logic                bit_last;
    logic                reg_last;
    logic [CH_IDX_W-1:0] arb_grant;
    logic                arb_valid;

    // Power pins carry no logic; this only marks them as intentionally read.
    logic unused_pwr;
    assign unused_pwr = DVDD ^ DVSS;

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .req       (ch_req),
        .last_grant(last_grant_q),
        .grant     (arb_grant),
        .valid     (arb_valid)
    );

    always_comb begin
        bit_last  = (bit_cnt_q == BC_W'(BITS_PER_REG - 1));
        reg_last  = (reg_idx_q == RI_W'(NUM_REGS_PER_CH - 1));
        bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
        reg_idx_d = bit_last ? reg_idx_q + 1'b1 : reg_idx_q;
    end

    // addr is registered from the next register index so the address shown
    // in each SHIFT cycle always belongs to that cycle's reg_idx.
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cur_ch_q     <= '0;
            busy_q       <= 1'b0;
            ch_ack_q     <= '0;
            bit_cnt_q    <= '0;
            reg_idx_q    <= '0;
            last_grant_q <= CH_IDX_W'(NUM_CH - 1);
        end else begin
            ch_ack_q <= '0;
            case (state_q)
                IDLE: begin
                    addr_q <= '0;
                    busy_q <= 1'b0;
                    if (enable && |ch_req) begin
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ARB: begin
                    if (arb_valid) begin
                        state_q   <= SHIFT;
                        cur_ch_q  <= arb_grant;
                        bit_cnt_q <= '0;
                        reg_idx_q <= '0;
                        addr_q    <= ch_reg_addr(CH_REG_START_ADDR, NUM_REGS_PER_CH,
                                                 32'(arb_grant), 0);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    bit_cnt_q <= bit_cnt_d;
                    reg_idx_q <= reg_idx_d;
                    if (bit_last && reg_last) begin
                        state_q      <= DONE;
                        addr_q       <= '0;
                        busy_q       <= 1'b0;
                        reg_idx_q    <= '0;
                        ch_ack_q     <= NUM_CH'(1) << cur_ch_q;
                        last_grant_q <= cur_ch_q;
                    end else begin
                        addr_q <= ch_reg_addr(CH_REG_START_ADDR, NUM_REGS_PER_CH,
                                              32'(cur_ch_q), 32'(reg_idx_d));
                    end
                end
                default: begin
                    if (enable && |ch_req) begin
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign addr   = addr_q;
    assign cur_ch = cur_ch_q;
    assign busy   = busy_q;
    assign ch_ack = ch_ack_q;

endmodule

// File: tb/tb_readout_scheduler.sv
// Self-checking bench for readout_scheduler: a frame-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_readout_scheduler;

    localparam int START     = 12;
    localparam int NREG      = 7;
    localparam int NCH       = 8;
    localparam int BITS      = 8;
    localparam int FRAME_LEN = NREG * BITS;

    logic       spi_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       enable  = 1'b0;
    logic [7:0] ch_req  = 8'h00;
    logic [6:0] addr;
    logic [2:0] cur_ch;
    logic       busy;
    logic [7:0] ch_ack;
    wire        dvdd;
    wire        dvss;

    assign dvdd = 1'b1;
    assign dvss = 1'b0;

    always #5 spi_clk = ~spi_clk;

    readout_scheduler #(
        .CH_REG_START_ADDR(START),
        .NUM_REGS_PER_CH  (NREG),
        .NUM_CH           (NCH),
        .BITS_PER_REG     (BITS)
    ) dut (
        .spi_clk(spi_clk),
        .rst    (rst),
        .DVDD   (dvdd),
        .DVSS   (dvss),
        .enable (enable),
        .ch_req (ch_req),
        .addr   (addr),
        .cur_ch (cur_ch),
        .busy   (busy),
        .ch_ack (ch_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // phase 0: nothing pending, 1: choosing a channel, 2: in frame, 3: acking
    int m_phase = 0;
    int m_pos   = 0;
    int m_ch    = 0;
    int m_last  = NCH - 1;
    bit model_valid = 1'b0;

    function automatic int pick(input logic [7:0] r, input int last);
        logic [2:0] c;
        for (int k = 1; k <= NCH; k++) begin
            c = 3'((last + k) % NCH);
            if (r[c]) return int'(c);
        end
        return 0;
    endfunction

    always @(posedge spi_clk) begin
        if (rst) begin
            model_valid <= 1'b1;
            m_phase     <= 0;
            m_pos       <= 0;
            m_ch        <= 0;
            m_last      <= NCH - 1;
        end else if (model_valid) begin
            case (m_phase)
                0: if (enable && ch_req != 0) m_phase <= 1;
                1: begin
                    if (ch_req == 0) m_phase <= 0;
                    else begin
                        m_ch    <= pick(ch_req, m_last);
                        m_pos   <= 0;
                        m_phase <= 2;
                    end
                end
                2: begin
                    if (m_pos == FRAME_LEN - 1) begin
                        m_last  <= m_ch;
                        m_phase <= 3;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
                default: m_phase <= (enable && ch_req != 0) ? 1 : 0;
            endcase
        end
    end

    always @(negedge spi_clk) begin
        if (model_valid) begin
            chk("model_addr", 32'(addr),
                (m_phase == 2) ? 32'(START + m_ch * NREG + m_pos / BITS) : 32'd0);
            chk("model_busy", 32'(busy), (m_phase == 1 || m_phase == 2) ? 32'd1 : 32'd0);
            chk("model_ack", 32'(ch_ack), (m_phase == 3) ? (32'd1 << m_ch) : 32'd0);
            chk("model_cur_ch", 32'(cur_ch), 32'(m_ch));
        end
    end

    // ---------------- output logs ----------------
    int addr_log[$];
    int ack_log[$];

    always @(negedge spi_clk) begin
        if (model_valid && !rst) begin
            if (addr != 0) addr_log.push_back(int'(addr));
            if (ch_ack != 0) ack_log.push_back(int'(ch_ack));
        end
    end

    task automatic tick();
        @(negedge spi_clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        ack_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_ack(input string name, output logic [7:0] ack);
        ack = 8'h00;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ch_ack != 0) begin
                ack = ch_ack;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: no ch_ack within 200 cycles, got 0 expected pulse", name);
    endtask

    task automatic wait_addr(input string name);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (addr != 0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: no address within 20 cycles, got 0 expected nonzero", name);
    endtask

    logic [7:0] ack_v;

    initial begin
        // reset state
        do_reset();
        chk("rst_addr", 32'(addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_ack", 32'(ch_ack), 0);

        // single channel 0 frame, including request-to-address latency
        ch_req = 8'h01;
        enable = 1'b1;
        tick();
        chk("lat_arb_busy", 32'(busy), 1);
        chk("lat_arb_addr", 32'(addr), 0);
        tick();
        chk("lat_first_addr", 32'(addr), 12);
        wait_ack("ch0_ack_wait", ack_v);
        ch_req = 8'h00;
        chk("ch0_ack", 32'(ack_v), 32'h01);
        chk("ch0_len", 32'(addr_log.size()), 56);
        chk("ch0_a0", 32'(addr_log[0]), 12);
        chk("ch0_a7", 32'(addr_log[7]), 12);
        chk("ch0_a8", 32'(addr_log[8]), 13);
        chk("ch0_a55", 32'(addr_log[55]), 18);
        tick();
        chk("ch0_idle_busy", 32'(busy), 0);

        // all channels requesting: full round-robin sweep plus wrap
        do_reset();
        ch_req = 8'hFF;
        enable = 1'b1;
        for (int f = 0; f < 9; f++) wait_ack("rr_ack_wait", ack_v);
        ch_req = 8'h00;
        chk("rr_ack_count", 32'(ack_log.size()), 9);
        for (int f = 0; f < 9 && f < ack_log.size(); f++)
            chk("rr_ack_order", 32'(ack_log[f]), 32'd1 << (f % 8));
        chk("rr_addr_count", 32'(addr_log.size()), 9 * 56);
        if (addr_log.size() >= 8 * 56) begin
            chk("rr_ch7_first", 32'(addr_log[7 * 56]), 61);
            chk("rr_ch7_last", 32'(addr_log[7 * 56 + 55]), 67);
        end

        // ch2 re-granted after itself, enable dropped mid-frame
        do_reset();
        ch_req = 8'h04;
        enable = 1'b1;
        wait_ack("ch2_first_wait", ack_v);
        chk("ch2_first_ack", 32'(ack_v), 32'h04);
        clear_logs();
        wait_addr("ch2_second_start");
        chk("ch2_cur_ch", 32'(cur_ch), 2);
        repeat (20) tick();
        enable = 1'b0;
        wait_ack("ch2_second_wait", ack_v);
        chk("ch2_second_ack", 32'(ack_v), 32'h04);
        chk("ch2_len", 32'(addr_log.size()), 56);
        chk("ch2_a0", 32'(addr_log[0]), 26);
        chk("ch2_a55", 32'(addr_log[55]), 32);
        tick();
        chk("ch2_idle_busy", 32'(busy), 0);
        tick();
        chk("ch2_idle_busy2", 32'(busy), 0);
        chk("ch2_idle_addr", 32'(addr), 0);
        ch_req = 8'h00;

        // reset mid-frame of ch3 aborts it; priority returns to ch0
        do_reset();
        ch_req = 8'h08;
        enable = 1'b1;
        wait_addr("ch3_start");
        chk("ch3_a0", 32'(addr), 33);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        chk("abort_addr", 32'(addr), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'(ch_ack), 0);
        rst = 1'b0;
        ch_req = 8'h09;
        wait_addr("after_abort_start");
        chk("after_abort_addr", 32'(addr), 12);
        chk("after_abort_cur_ch", 32'(cur_ch), 0);
        chk("abort_no_ack", 32'(ack_log.size()), 0);
        ch_req = 8'h00;

        // request withdrawn during arbitration
        do_reset();
        enable = 1'b1;
        ch_req = 8'h10;
        tick();
        chk("wd_arb_busy", 32'(busy), 1);
        ch_req = 8'h00;
        tick();
        chk("wd_busy", 32'(busy), 0);
        repeat (10) tick();
        chk("wd_no_addr", 32'(addr_log.size()), 0);
        chk("wd_no_ack", 32'(ack_log.size()), 0);

        // granted channel drops its request, a lower one arrives mid-frame
        do_reset();
        enable = 1'b1;
        ch_req = 8'h02;
        wait_addr("swap_start");
        chk("swap_a0", 32'(addr), 19);
        ch_req = 8'h01;
        wait_ack("swap_ack1_wait", ack_v);
        chk("swap_ack1", 32'(ack_v), 32'h02);
        wait_addr("swap_second_start");
        chk("swap_second_addr", 32'(addr), 12);
        wait_ack("swap_ack2_wait", ack_v);
        ch_req = 8'h00;
        chk("swap_ack2", 32'(ack_v), 32'h01);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
